// File: rtl/evtlog_pkg.sv
// evtlog_pkg: record layout, widths and event indices shared by the event logger.
package evtlog_pkg;
  localparam int EVT_W = 3;
  localparam int TS_W = 12;
  localparam int REC_W = 32;
  localparam int MASK_LSB = 29;
  localparam int LOST_BIT = 28;
  localparam int TS_LSB = 16;
  localparam int C2_LSB = 8;
  localparam int C1_LSB = 0;
  typedef enum int {EQ00 = 0, EQ80 = 1, EQFF = 2} evt_idx_e;
  typedef struct packed {
    logic [EVT_W-1:0] mask;
    logic lost;
    logic [TS_W-1:0] ts;
    logic [7:0] c2;
    logic [7:0] c1;
  } rec_t;
  function automatic logic [REC_W-1:0] mk_rec(logic [EVT_W-1:0] mask, logic lost,
                                             logic [TS_W-1:0] ts, logic [7:0] c2, logic [7:0] c1);
    mk_rec = '0;
    mk_rec[MASK_LSB +: EVT_W] = mask;
    mk_rec[LOST_BIT] = lost;
    mk_rec[TS_LSB +: TS_W] = ts;
    mk_rec[C2_LSB +: 8] = c2;
    mk_rec[C1_LSB +: 8] = c1;
  endfunction
endpackage

// File: rtl/counter_event_logger_if.sv
// counter_event_logger_if: host readout path of the event logger (pop strobe, head record, status).
interface counter_event_logger_if #(parameter int DEPTH = 16, parameter int DROP_W = 8);
  logic rd_en;
  logic [31:0] rec_dout;
  logic [$clog2(DEPTH):0] rec_count;
  logic empty;
  logic full;
  logic [DROP_W-1:0] drop_cnt;
  modport master (output rd_en, input rec_dout, rec_count, empty, full, drop_cnt);
  modport slave (input rd_en, output rec_dout, rec_count, empty, full, drop_cnt);
endinterface

// File: rtl/evtlog_fifo.sv
// evtlog_fifo: show-ahead FIFO; head word on dout (0 when empty), push+pop on full both honoured.
module evtlog_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // On full with a pop, wp == rp: the head is read out this cycle before the slot is overwritten.
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wp] <= din;
endmodule

// File: rtl/counter_event_logger.sv
// counter_event_logger: edge-detects counter flags and queues stamped records for host readout.
// Optional timestamp counter enabled with EVTLOG_TIMESTAMP_EN; otherwise bits [27:16] are 0.
module counter_event_logger
  import evtlog_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DROP_W = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic [7:0] count1,
  input  logic [7:0] count2,
  input  logic [EVT_W-1:0] evt_in,
  input  logic [EVT_W-1:0] evt_en,
  input  logic ts_tick,
  input  logic clear,
  counter_event_logger_if.slave rd
);
  logic [EVT_W-1:0] evt_q, rise;
  logic [TS_W-1:0] ts;
  logic [DROP_W-1:0] drop_cnt;
  logic lost, push, drop, accept;
  assign rise = evt_in & ~evt_q & evt_en;
  assign push = |rise && !clear;
  assign drop = push && rd.full && !rd.rd_en;
  assign accept = push && !drop;
  assign rd.drop_cnt = drop_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      evt_q <= '0;
      lost <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      evt_q <= evt_in;
      lost <= 1'b0;
      drop_cnt <= '0;
    end else begin
      evt_q <= evt_in;
      if (drop) lost <= 1'b1;
      else if (accept) lost <= 1'b0;
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
`ifdef EVTLOG_TIMESTAMP_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) ts <= '0;
    else if (clear) ts <= '0;
    else if (ts_tick) ts <= ts + TS_W'(1);
`else
  logic unused_ts_tick;
  assign ts = '0;
  assign unused_ts_tick = ts_tick;
`endif
  evtlog_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .clear(clear),
    .push(accept),
    .din(mk_rec(rise, lost, ts, count2, count1)),
    .pop(rd.rd_en),
    .dout(rd.rec_dout),
    .count(rd.rec_count),
    .empty(rd.empty),
    .full(rd.full)
  );
endmodule

// File: tb/tb_counter_event_logger.sv
// tb_counter_event_logger: table vectors for basic edges, then a queue scoreboard for overflow/clear/wrap/reset.
module tb_counter_event_logger;
  localparam int DEPTH = 16;
  localparam int DROP_W = 8;
  logic sys_clk = 0, sys_rst_n = 0, ts_tick = 0, clear = 0;
  logic [7:0] count1 = 0, count2 = 0;
  logic [2:0] evt_in = 0, en = 3'b111;
  int pass = 0, total = 0;
  logic [31:0] mq[$];
  logic [7:0] mdrop = 0;
  logic mlost = 0;
  logic [2:0] mevq = 0;
  int mts = 0;
  counter_event_logger_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) rd_if ();
  counter_event_logger #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .count1(count1), .count2(count2),
    .evt_in(evt_in), .evt_en(en), .ts_tick(ts_tick), .clear(clear), .rd(rd_if)
  );
  always #5 sys_clk = ~sys_clk;
  function automatic logic [11:0] tsv(int t);
`ifdef EVTLOG_TIMESTAMP_EN
    return 12'(t);
`else
    return 12'(t * 0);
`endif
  endfunction
  function automatic logic [31:0] mk(logic [2:0] m, logic l, int t, logic [7:0] c2, logic [7:0] c1);
    return {m, l, tsv(t), c2, c1};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  task automatic chk_all();
    chk("dout", rd_if.rec_dout, mq.size() > 0 ? mq[0] : 32'h0);
    chk("count", 32'(rd_if.rec_count), 32'(mq.size()));
    chk("empty", 32'(rd_if.empty), 32'(mq.size() == 0));
    chk("full", 32'(rd_if.full), 32'(mq.size() == DEPTH));
    chk("drop", 32'(rd_if.drop_cnt), 32'(mdrop));
  endtask
  task automatic cyc(input logic [2:0] e, input logic [7:0] a, input logic [7:0] b,
                     input logic tk, input logic cl, input logic r);
    logic [2:0] rs;
    logic pp;
    evt_in = e; count1 = a; count2 = b; ts_tick = tk; clear = cl; rd_if.rd_en = r;
    rs = e & ~mevq & en;
    if (cl) begin
      mq.delete(); mdrop = 0; mts = 0; mlost = 0;
    end else begin
      pp = r && mq.size() > 0;
      if (rs != 0) begin
        if (mq.size() == DEPTH && !pp) begin
          if (mdrop != 8'hFF) mdrop++;
          mlost = 1;
        end else begin
          mq.push_back(mk(rs, mlost, mts, b, a));
          mlost = 0;
        end
      end
      if (pp) void'(mq.pop_front());
      if (tk) mts = (mts + 1) % 4096;
    end
    mevq = e;
    @(posedge sys_clk);
    #1;
    chk_all();
  endtask
  typedef struct {
    logic [2:0] evt, msk;
    logic [7:0] c1, c2;
    logic tick, rd;
    logic [31:0] dout;
    int cnt;
  } vec_t;
  vec_t tv[15];
  initial begin
    for (int i = 0; i < 5; i++) tv[i] = '{3'b000, 3'b111, 8'h00, 8'h00, 1'b1, 1'b0, 32'h0, 0};
    tv[5]  = '{3'b001, 3'b111, 8'h00, 8'h37, 1'b0, 1'b0, mk(3'b001, 0, 5, 8'h37, 8'h00), 1};
    tv[6]  = '{3'b001, 3'b111, 8'h01, 8'h37, 1'b0, 1'b0, mk(3'b001, 0, 5, 8'h37, 8'h00), 1};
    tv[7]  = '{3'b000, 3'b111, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0, 0};
    tv[8]  = '{3'b101, 3'b111, 8'h00, 8'hFF, 1'b1, 1'b0, mk(3'b101, 0, 5, 8'hFF, 8'h00), 1};
    tv[9]  = '{3'b101, 3'b111, 8'h00, 8'hFF, 1'b0, 1'b1, 32'h0, 0};
    tv[10] = '{3'b010, 3'b101, 8'h80, 8'h00, 1'b0, 1'b0, 32'h0, 0};
    tv[11] = '{3'b000, 3'b111, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 0};
    tv[12] = '{3'b010, 3'b111, 8'h80, 8'h12, 1'b0, 1'b0, mk(3'b010, 0, 6, 8'h12, 8'h80), 1};
    tv[13] = '{3'b010, 3'b111, 8'h80, 8'h12, 1'b0, 1'b1, 32'h0, 0};
    tv[14] = '{3'b000, 3'b111, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0, 0};
    rd_if.rd_en = 0;
    #12;
    chk("rst_dout", rd_if.rec_dout, 32'h0);
    chk("rst_count", 32'(rd_if.rec_count), 32'h0);
    chk("rst_empty", 32'(rd_if.empty), 32'h1);
    chk("rst_full", 32'(rd_if.full), 32'h0);
    chk("rst_drop", 32'(rd_if.drop_cnt), 32'h0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1;
    foreach (tv[i]) begin
      evt_in = tv[i].evt; en = tv[i].msk; count1 = tv[i].c1; count2 = tv[i].c2;
      ts_tick = tv[i].tick; rd_if.rd_en = tv[i].rd;
      @(posedge sys_clk);
      #1;
      chk($sformatf("vec%0d_dout", i), rd_if.rec_dout, tv[i].dout);
      chk($sformatf("vec%0d_count", i), 32'(rd_if.rec_count), 32'(tv[i].cnt));
    end
    en = 3'b111;
    cyc(3'b000, 0, 0, 0, 1, 0);
    // overflow: DEPTH+3 events, then the lost marker on the next accepted record only
    for (int i = 0; i < DEPTH + 3; i++) begin
      cyc(3'b001, 8'(i), 8'hA0, 0, 0, 0);
      cyc(3'b000, 0, 0, 0, 0, 0);
    end
    chk("ovf_full", 32'(rd_if.full), 32'h1);
    chk("ovf_drop", 32'(rd_if.drop_cnt), 32'h3);
    cyc(3'b000, 0, 0, 0, 0, 1);
    cyc(3'b001, 8'hC1, 8'hA1, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0, 1);
    cyc(3'b001, 8'hC2, 8'hA2, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH && rd_if.rec_count > 2; k++) cyc(3'b000, 0, 0, 0, 0, 1);
    chk("lost_set", 32'(rd_if.rec_dout[28]), 32'h1);
    chk("lost_set_c1", 32'(rd_if.rec_dout[7:0]), 32'hC1);
    cyc(3'b000, 0, 0, 0, 0, 1);
    chk("lost_clr", 32'(rd_if.rec_dout[28]), 32'h0);
    cyc(3'b000, 0, 0, 0, 0, 1);
    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      cyc(3'b001, 8'(i + 16), 8'hB0, 1, 0, 0);
      cyc(3'b000, 0, 0, 0, 0, 0);
    end
    cyc(3'b001, 8'hEE, 8'hB1, 0, 0, 1);
    chk("pp_count", 32'(rd_if.rec_count), 32'(DEPTH));
    chk("pp_drop", 32'(rd_if.drop_cnt), 32'h3);
    cyc(3'b000, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) cyc(3'b000, 0, 0, 0, 0, 1);
    // clear with records queued, a held flag and a fresh rise in the clear cycle
    for (int i = 0; i < 5; i++) begin
      cyc(3'b000, 0, 0, 0, 0, 0);
      cyc(3'b100, 8'(i), 8'hFF, 0, 0, 0);
    end
    cyc(3'b101, 8'h55, 8'hFF, 0, 1, 1);
    chk("clr_empty", 32'(rd_if.empty), 32'h1);
    chk("clr_drop", 32'(rd_if.drop_cnt), 32'h0);
    cyc(3'b101, 8'h56, 8'hFF, 0, 0, 0);
    chk("clr_norefire", 32'(rd_if.rec_count), 32'h0);
    // timestamp wrap
    cyc(3'b000, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4097; k++) cyc(3'b000, 0, 0, 1, 0, 0);
    cyc(3'b001, 8'h00, 8'h11, 0, 0, 0);
    chk("ts_wrap", 32'(rd_if.rec_dout[27:16]), 32'(tsv(1)));
    cyc(3'b000, 0, 0, 0, 0, 1);
    // async reset mid-stream with a flag held across the release
    cyc(3'b010, 8'h80, 8'h01, 0, 0, 0);
    cyc(3'b000, 0, 0, 0, 0, 0);
    cyc(3'b001, 8'h00, 8'h02, 0, 0, 0);
    #3;
    sys_rst_n = 0;
    #1;
    chk("arst_dout", rd_if.rec_dout, 32'h0);
    chk("arst_count", 32'(rd_if.rec_count), 32'h0);
    chk("arst_empty", 32'(rd_if.empty), 32'h1);
    chk("arst_full", 32'(rd_if.full), 32'h0);
    mq.delete(); mdrop = 0; mts = 0; mlost = 0; mevq = 0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1;
    cyc(3'b001, 8'h00, 8'h03, 0, 0, 0);
    cyc(3'b001, 8'h00, 8'h04, 0, 0, 0);
    chk("post_rst_one", 32'(rd_if.rec_count), 32'h1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/counter_event_logger.md
# counter_event_logger

Event capture stage downstream of the two board counters. It detects rising edges on the counter-condition flags (count1 == 0x00, count1 == 0x80, count2 == 0xFF), and stamps each event with both counter values and a tick-based timestamp. Each record is buffered in a small show-ahead FIFO that the host drains through a wire/pipe-out readout path. All logic runs on `sys_clk`, alongside the counters it observes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in records; power of two, 4..256.
- `DROP_W`, 8: width of the saturating drop counter.

Ports (one clock; reset is asynchronous and active-low):
- `sys_clk`  in  1: system clock, same domain as the counters.
- `sys_rst_n`  in  1: asynchronous active-low reset.
- `count1`  in  8: counter 1 value.
- `count2`  in  8: counter 2 value.
- `evt_in`  in  3: level flags {count2eqFF, count1eq80, count1eq00}.
- `evt_en`  in  3: per-bit event enable mask.
- `ts_tick`  in  1: one-cycle timestamp advance pulse (divided-clock strobe).
- `clear`  in  1: synchronous flush pulse.
- `rd_en`  in  1: pop strobe from the readout endpoint.
- `rec_dout`  out  32: head record; 0 when empty.
- `rec_count`  out  $clog2(DEPTH)+1: records held.
- `empty`  out  1: FIFO empty.
- `full`  out  1: FIFO full.
- `drop_cnt`  out  DROP_W: events lost to a full FIFO; saturates.

## Operation
- Record format:
  - [31:29]: event mask (rising edges seen this cycle).
  - [28]: lost marker.
  - [27:16]: timestamp.
  - [15:8]: count2.
  - [7:0]: count1.
- Edge detect:
  - `evt_q` holds the previous `evt_in`.
  - `rise = evt_in & ~evt_q & evt_en`.
  - Multiple simultaneous rises produce one record with several mask bits set.
- Push occurs on any cycle where `rise != 0`. The pushed record captures `count1`, `count2` and the timestamp as sampled on that same edge.
- Timestamp: 12-bit counter, +1 per `ts_tick`. It wraps 0xFFF→0x000 silently. The record carries the pre-increment value.
- Full FIFO:
  - If push and no pop: the record is discarded, `drop_cnt` increments (saturating at all-ones), and the internal `lost` flag is set.
  - The next accepted record carries [28]=1, and `lost` clears on that write.
- Push and pop in the same cycle are both honoured, including when the FIFO is full. Count is unchanged and nothing is dropped.
- `rd_en` while empty is ignored; no underflow.
- `clear` has priority over push and pop. It:
  - empties the FIFO,
  - zeroes `drop_cnt`, the timestamp and `lost`,
  - loads `evt_q <= evt_in`, so held-high flags do not re-fire.
- An event that rises in the same cycle as `clear` is discarded.
- Reset (async, `sys_rst_n` low):
  - `rec_dout`=0, `rec_count`=0, `empty`=1, `full`=0, `drop_cnt`=0.
  - Timestamp=0, `lost`=0, `evt_q`=0.
  - Consequence: a flag already high when reset releases produces one record on the first clock.

## Timing
- Push latency is 1 cycle. For an edge seen at clock N, the record is visible on `rec_dout` at N+1 if the FIFO was empty. `rec_count`, `empty` and `full` also update at N+1.
- Show-ahead read: `rec_dout` is valid whenever `empty`=0. After an `rd_en` at edge N, the next record (or 0) is presented at N+1.
- All outputs are registered or driven directly from registers; no combinational input-to-output paths.
- `ts_tick` and a push on the same edge: the record gets the old timestamp value.

## Configuration
- Macro: `EVTLOG_TIMESTAMP_EN`.
- Defined: 12-bit timestamp counter present; bits [27:16] carry the stamp.
- Undefined: no timestamp counter; bits [27:16] are 0 and `ts_tick` is unused. Everything else is identical.

## Structure
- Package `evtlog_pkg`:
  - `EVT_W`=3, `TS_W`=12.
  - Record field bit positions and the record struct/typedef.
  - Event bit indices (EQ00=0, EQ80=1, EQFF=2).
- Sub-module `evtlog_fifo`: synchronous show-ahead FIFO. It carries parameters `WIDTH`/`DEPTH` and ports push/pop/dout/count/empty/full, with simultaneous push and pop on full allowed.
- Top level holds the edge detect, timestamp, lost/drop logic and clear handling.

## Test plan
- Single event: raise `evt_in[0]` with count1=0x00, count2=0x37, ts=5 → next cycle `rec_dout`=0x2005_3700 (mask 001), `rec_count`=1; holding the flag high adds no further records.
- Simultaneous events: `evt_in[0]` and `evt_in[2]` rise together → one record with [31:29]=101.
- Overflow: DEPTH+3 events with no reads → `full`=1, `drop_cnt`=3; pop one, raise another event → new record has [28]=1, and the following record has [28]=0.
- Full with push and pop in the same cycle → `rec_count` stays DEPTH, `drop_cnt` unchanged, order preserved.
- Timestamp wrap: 4097 `ts_tick` pulses, then an event → stamp = 0x001; with `EVTLOG_TIMESTAMP_EN` undefined → [27:16]=0.
- Clear and reset: `clear` with 5 records queued and a flag held high → `empty`=1, `drop_cnt`=0, no new record; asserting `sys_rst_n` low mid-stream → all outputs return to their reset values immediately.
